spi_reg_receiver: RTL and testbench
===================================

Name: spi_reg_receiver

Overview:
- SPI Mode-0 write-only register front end.
- Sits directly upstream of pwm_peripheral and drives its five 8-bit control registers from the ui_in SPI pins.
- Pin inputs are asynchronous. They are synchronized into clk, edge-detected, shifted into 16-bit frames and committed to the register file on nCS deassert.

Parameters:
SYNC_STAGES, 2, flops per input synchronizer chain (legal values >= 2)

Ports:
clk  input  1  system clock; sole clock
rst  input  1  reset, synchronous, active-high
sclk  input  1  SPI clock (asynchronous pin)
copi  input  1  SPI data in (asynchronous pin)
ncs  input  1  SPI chip select, active-low (asynchronous pin)
cipo  output  1  SPI data out (readback, see Optional Feature)
en_reg_out_7_0  output  8  register addr 0
en_reg_out_15_8  output  8  register addr 1
en_reg_pwm_7_0  output  8  register addr 2
en_reg_pwm_15_8  output  8  register addr 3
pwm_duty_cycle  output  8  register addr 4
addr_out  output  3  address of last accepted write
wr_strobe  output  1  one-cycle pulse on accepted write

Behaviour:
- Reset, sampled on clk only:
  - All register outputs, addr_out, wr_strobe and cipo = 0.
  - FSM = IDLE; bit_cnt = 0; overflow flag cleared.
  - Sync chains preload sclk=0, copi=0, ncs=1, so no false edge follows reset.
- Synchronizers: SYNC_STAGES flops per input. One extra flop on synced sclk and synced ncs holds the previous value for edge detection.
  - sclk_rise = s & ~prev; sclk_fall = ~s & prev; ncs_fall / ncs_rise likewise.
- Frame format, MSB first, 16 bits: bit15 = R/W (1 = write), bits14:8 = 7-bit address, bits7:0 = data.
- FSM:
  - IDLE: on ncs_fall -> SHIFT; clear bit_cnt and overflow. All sclk edges are ignored in IDLE.
  - SHIFT, on sclk_rise with synced ncs low:
    - shift <= {shift[14:0], copi_s}.
    - bit_cnt increments and saturates at 16.
    - A rise arriving when bit_cnt == 16 sets overflow.
  - SHIFT, on ncs_rise:
    - bit_cnt == 16 and no overflow -> COMMIT.
    - Otherwise -> IDLE; the frame is discarded with no register change.
  - COMMIT (exactly one cycle), then -> IDLE.
    - Write to address 0-4: the addressed register <= data; addr_out <= address[2:0]; wr_strobe = 1 for this cycle only.
    - Read frame, or address 5-127: no register change, addr_out unchanged, no strobe.
- Simultaneous sclk_rise and ncs_rise in the same cycle: ncs_rise wins and the sclk edge is not counted.
- Latency: the written value is visible on its output immediately after clk edge SYNC_STAGES+2.
  - Edge 1 is the first clk edge at which the ncs pin is sampled high.
  - wr_strobe is high during the cycle preceding that edge.
- A new ncs_fall during COMMIT is not lost. Synced ncs is still high during COMMIT, so the fall is detected afterwards from IDLE.
- Reset mid-frame: the frame is abandoned and all registers return to 0. A frame still in progress when rst releases is ignored until the next ncs_fall.
- Registers hold their value indefinitely between writes. A second write to the same address simply overwrites it.
- cipo = 0 whenever synced ncs is high.

Optional Feature:
Macro SPI_READBACK_EN.
- Defined:
  - In a read frame (bit15 = 0), on the cycle that bit_cnt reaches 8, load an 8-bit readback register with the addressed register's value (0 for address >= 5).
  - cipo drives its MSB; each sclk_fall while bit_cnt is 8-15 shifts it left, filling with 0.
  - Master sees data on its rising edges 9-16.
  - Write frames drive cipo = 0.
- Not defined: cipo is tied to constant 0 and no readback logic exists.

Test Plan:
- Write frame 0x80A5 (addr 0, data 0xA5) -> en_reg_out_7_0 = 0xA5 after edge SYNC_STAGES+2; wr_strobe single pulse; addr_out = 0; other registers remain 0.
- Write frame 0x8480 -> pwm_duty_cycle = 0x80 and addr_out = 4. Then a write 0x8133 -> en_reg_out_15_8 = 0x33 and pwm_duty_cycle still 0x80.
- Frame of 15 clocks, and separately 17 clocks, with data 0xFF to addr 2 -> en_reg_pwm_7_0 stays 0x00; no wr_strobe.
- Write frame 0x87FF (addr 7), then read frame 0x0200 -> no register change, no strobe, addr_out unchanged.
- With SPI_READBACK_EN: after writing 0x835A, read frame 0x0300 -> cipo bits sampled on rising edges 9-16 = 0x5A. Without the macro, cipo stays 0 throughout.
- Assert rst for 1 cycle after 10 bits of a write to addr 3, following an earlier write of 0x11 to addr 3 -> all outputs 0. The remaining 6 bits plus nCS rise produce no write; the next full frame 0x8377 -> en_reg_pwm_15_8 = 0x77.

Source files
------------

// File: rtl/spi_reg_receiver.sv
//------------------------------------------------------------------------------
// Module   : spi_reg_receiver
// Brief    : SPI Mode-0 write-only front end feeding five 8-bit control
//            registers. The optional readback path is enabled by defining
//            the macro SPI_READBACK_EN.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module spi_reg_receiver #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic       cipo,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic [2:0] addr_out,
  output logic       wr_strobe
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  // Synchronizers and edge detection
  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] copi_sync_q;
  logic [SYNC_STAGES-1:0] ncs_sync_q;
  logic                   sclk_prev_q;
  logic                   ncs_prev_q;
  logic                   sclk_s;
  logic                   copi_s;
  logic                   ncs_s;
  logic                   sclk_rise;
  logic                   sclk_fall;
  logic                   ncs_rise;
  logic                   ncs_fall;

  // Idle levels are preloaded so reset release never looks like an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_q <= '0;
      copi_sync_q <= '0;
      ncs_sync_q  <= '1;
      sclk_prev_q <= 1'b0;
      ncs_prev_q  <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      copi_sync_q <= {copi_sync_q[SYNC_STAGES-2:0], copi};
      ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], ncs};
      sclk_prev_q <= sclk_s;
      ncs_prev_q  <= ncs_s;
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign copi_s    = copi_sync_q[SYNC_STAGES-1];
  assign ncs_s     = ncs_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign ncs_rise  = ncs_s & ~ncs_prev_q;
  assign ncs_fall  = ~ncs_s & ncs_prev_q;

  // Frame shifter
  state_t      state_q;
  logic [15:0] shift_q;
  logic [15:0] shift_d;
  logic [4:0]  bit_cnt_q;
  logic [4:0]  bit_cnt_d;
  logic        overflow_q;
  logic        overflow_d;
  logic        shift_en;

  // ncs_rise implies synced ncs high, so a coincident sclk rise is dropped.
  assign shift_en = (state_q == ST_SHIFT) && sclk_rise && !ncs_s;

  always_comb begin
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    overflow_d = overflow_q;
    if (shift_en) begin
      shift_d = {shift_q[14:0], copi_s};
      if (bit_cnt_q == 5'd16) begin
        overflow_d = 1'b1;
      end else begin
        bit_cnt_d = bit_cnt_q + 5'd1;
      end
    end
  end

  logic       frame_write;
  logic [6:0] frame_addr;
  logic [7:0] frame_data;
  logic       commit_wr;
  logic       frame_good;

  assign frame_write = shift_q[15];
  assign frame_addr  = shift_q[14:8];
  assign frame_data  = shift_q[7:0];
  assign commit_wr   = frame_write && (frame_addr < 7'd5);
  assign frame_good  = (bit_cnt_q == 5'd16) && !overflow_q;

  // Register file and control FSM
  logic [7:0] reg0_q;
  logic [7:0] reg1_q;
  logic [7:0] reg2_q;
  logic [7:0] reg3_q;
  logic [7:0] reg4_q;
  logic [2:0] addr_out_q;
  logic       wr_strobe_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      overflow_q  <= 1'b0;
      reg0_q      <= '0;
      reg1_q      <= '0;
      reg2_q      <= '0;
      reg3_q      <= '0;
      reg4_q      <= '0;
      addr_out_q  <= '0;
      wr_strobe_q <= 1'b0;
    end else begin
      wr_strobe_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (ncs_fall) begin
            state_q    <= ST_SHIFT;
            bit_cnt_q  <= '0;
            overflow_q <= 1'b0;
          end
        end
        ST_SHIFT: begin
          if (ncs_rise) begin
            if (frame_good) begin
              state_q     <= ST_COMMIT;
              wr_strobe_q <= commit_wr;
            end else begin
              state_q <= ST_IDLE;
            end
          end else begin
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            overflow_q <= overflow_d;
          end
        end
        ST_COMMIT: begin
          if (commit_wr) begin
            addr_out_q <= frame_addr[2:0];
            case (frame_addr[2:0])
              3'd0:    reg0_q <= frame_data;
              3'd1:    reg1_q <= frame_data;
              3'd2:    reg2_q <= frame_data;
              3'd3:    reg3_q <= frame_data;
              default: reg4_q <= frame_data;
            endcase
          end
          // A chip-select fall seen here must still open the next frame.
          if (ncs_fall) begin
            state_q    <= ST_SHIFT;
            bit_cnt_q  <= '0;
            overflow_q <= 1'b0;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign en_reg_out_7_0  = reg0_q;
  assign en_reg_out_15_8 = reg1_q;
  assign en_reg_pwm_7_0  = reg2_q;
  assign en_reg_pwm_15_8 = reg3_q;
  assign pwm_duty_cycle  = reg4_q;
  assign addr_out        = addr_out_q;
  assign wr_strobe       = wr_strobe_q;

`ifdef SPI_READBACK_EN
  logic [7:0] rb_q;
  logic       cipo_q;
  logic [7:0] rb_hdr;
  logic [7:0] rb_sel;
  logic       rb_load;
  logic       rb_shift;

  assign rb_hdr   = {shift_q[6:0], copi_s};
  assign rb_load  = shift_en && (bit_cnt_q == 5'd7);
  assign rb_shift = (state_q == ST_SHIFT) && sclk_fall &&
                    (bit_cnt_q >= 5'd8) && (bit_cnt_q <= 5'd15);

  always_comb begin
    rb_sel = 8'h00;
    case (rb_hdr[6:0])
      7'd0:    rb_sel = reg0_q;
      7'd1:    rb_sel = reg1_q;
      7'd2:    rb_sel = reg2_q;
      7'd3:    rb_sel = reg3_q;
      7'd4:    rb_sel = reg4_q;
      default: rb_sel = 8'h00;
    endcase
  end

  // The MSB is launched on the falling edge after bit 8 so the master's
  // rising edges 9..16 see bits 7..0.
  always_ff @(posedge clk) begin
    if (rst || ncs_s) begin
      rb_q   <= '0;
      cipo_q <= 1'b0;
    end else if (rb_load) begin
      rb_q <= rb_hdr[7] ? 8'h00 : rb_sel;
    end else if (rb_shift) begin
      cipo_q <= rb_q[7];
      rb_q   <= {rb_q[6:0], 1'b0};
    end
  end

  assign cipo = cipo_q & ~ncs_s;
`else
  assign cipo = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_spi_reg_receiver.sv
// Directed bench for spi_reg_receiver: bit-banged SPI frames, immediate-assertion checks.
`timescale 1ns/1ps
`default_nettype none

module tb_spi_reg_receiver;
  localparam int HALF = 6;

  logic       clk = 1'b0;
  logic       rst;
  logic       sclk;
  logic       copi;
  logic       ncs;
  logic       cipo;
  logic [7:0] r0;
  logic [7:0] r1;
  logic [7:0] r2;
  logic [7:0] r3;
  logic [7:0] r4;
  logic [2:0] addr_out;
  logic       wr_strobe;

  int          checks = 0;
  int          errors = 0;
  int          strobe_cnt = 0;
  int          base;
  logic [15:0] rx_q;

  spi_reg_receiver #(.SYNC_STAGES(2)) dut (
    .clk             (clk),
    .rst             (rst),
    .sclk            (sclk),
    .copi            (copi),
    .ncs             (ncs),
    .cipo            (cipo),
    .en_reg_out_7_0  (r0),
    .en_reg_out_15_8 (r1),
    .en_reg_pwm_7_0  (r2),
    .en_reg_pwm_15_8 (r3),
    .pwm_duty_cycle  (r4),
    .addr_out        (addr_out),
    .wr_strobe       (wr_strobe)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (wr_strobe === 1'b1) strobe_cnt++;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_start();
    ncs  = 1'b0;
    rx_q = '0;
    wait_clk(HALF);
  endtask

  task automatic spi_bit(input logic b);
    copi = b;
    wait_clk(HALF);
    rx_q = {rx_q[14:0], cipo};
    sclk = 1'b1;
    wait_clk(HALF);
    sclk = 1'b0;
  endtask

  task automatic spi_end();
    wait_clk(HALF);
    ncs = 1'b1;
    wait_clk(10);
  endtask

  task automatic send_frame(input logic [15:0] f, input int n);
    spi_start();
    for (int i = 0; i < n; i++) spi_bit((i < 16) ? f[15-i] : 1'b1);
    spi_end();
  endtask

  initial begin
    rst  = 1'b1;
    sclk = 1'b0;
    copi = 1'b0;
    ncs  = 1'b1;
    wait_clk(3);
    rst = 1'b0;
    wait_clk(2);
    check("reset_regs", {r0 | r1 | r2 | r3 | r4, 8'h00}, 16'h0000);
    check("reset_addr", {13'd0, addr_out}, 16'h0000);
    check("reset_strobe", {15'd0, wr_strobe}, 16'h0000);
    check("reset_cipo", {15'd0, cipo}, 16'h0000);

    // Write 0x80A5 with cycle-exact latency checks
    base = strobe_cnt;
    spi_start();
    for (int i = 0; i < 16; i++) spi_bit(((16'h80A5 >> (15 - i)) & 16'h1) != 0);
    wait_clk(HALF);
    ncs = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("lat_e2_strobe", {15'd0, wr_strobe}, 16'h0000);
    @(posedge clk);
    #1;
    check("lat_e3_strobe", {15'd0, wr_strobe}, 16'h0001);
    check("lat_e3_reg", {8'h00, r0}, 16'h0000);
    @(posedge clk);
    #1;
    check("lat_e4_reg", {8'h00, r0}, 16'h00A5);
    check("lat_e4_strobe", {15'd0, wr_strobe}, 16'h0000);
    wait_clk(8);
    check("w1_addr", {13'd0, addr_out}, 16'h0000);
    check("w1_pulses", 16'(strobe_cnt - base), 16'd1);
    check("w1_others", {r1 | r2 | r3 | r4, 8'h00}, 16'h0000);

    send_frame(16'h8480, 16);
    check("w4_duty", {8'h00, r4}, 16'h0080);
    check("w4_addr", {13'd0, addr_out}, 16'h0004);
    send_frame(16'h8133, 16);
    check("w1b_reg", {8'h00, r1}, 16'h0033);
    check("w1b_duty_kept", {8'h00, r4}, 16'h0080);
    check("w1b_addr", {13'd0, addr_out}, 16'h0001);

    // Short and long frames must be discarded
    base = strobe_cnt;
    send_frame(16'h82FF, 15);
    check("short_reg", {8'h00, r2}, 16'h0000);
    send_frame(16'h82FF, 17);
    check("long_reg", {8'h00, r2}, 16'h0000);
    check("badlen_pulses", 16'(strobe_cnt - base), 16'd0);

    // Out-of-range write and a read frame change nothing
    send_frame(16'h87FF, 16);
    send_frame(16'h0200, 16);
    check("noop_pulses", 16'(strobe_cnt - base), 16'd0);
    check("noop_addr", {13'd0, addr_out}, 16'h0001);
    check("noop_regs", {r0, r1}, 16'hA533);
    check("noop_r2_r3", {r2, r3}, 16'h0000);

    // Readback
    send_frame(16'h835A, 16);
    check("w3_reg", {8'h00, r3}, 16'h005A);
    base = strobe_cnt;
    send_frame(16'h0300, 16);
`ifdef SPI_READBACK_EN
    check("readback_bits", rx_q, 16'h005A);
`else
    check("readback_bits", rx_q, 16'h0000);
`endif
    check("read_pulses", 16'(strobe_cnt - base), 16'd0);
    check("cipo_idle", {15'd0, cipo}, 16'h0000);

    // Reset in the middle of a frame
    send_frame(16'h8311, 16);
    check("pre_rst_reg", {8'h00, r3}, 16'h0011);
    spi_start();
    for (int i = 0; i < 10; i++) spi_bit(((16'h83AA >> (15 - i)) & 16'h1) != 0);
    rst = 1'b1;
    wait_clk(1);
    rst = 1'b0;
    check("midrst_regs", {r0 | r1 | r2 | r3 | r4, 8'h00}, 16'h0000);
    check("midrst_addr_strobe", {12'd0, addr_out, wr_strobe}, 16'h0000);
    check("midrst_cipo", {15'd0, cipo}, 16'h0000);
    base = strobe_cnt;
    for (int i = 10; i < 16; i++) spi_bit(((16'h83AA >> (15 - i)) & 16'h1) != 0);
    spi_end();
    check("tail_reg", {8'h00, r3}, 16'h0000);
    check("tail_pulses", 16'(strobe_cnt - base), 16'd0);
    send_frame(16'h8377, 16);
    check("post_rst_reg", {8'h00, r3}, 16'h0077);
    check("post_rst_addr", {13'd0, addr_out}, 16'h0003);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
